// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package pipe_mem_pkg;

    // Arbiter sequencing state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2
    } arb_st_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Word returned to IF on an aborted fetch: sll $0,$0,0 (a NOP)
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_mem_arb_wdog.sv
// Access watchdog: counts cycles an access waits for m_ready and flags
// expiry on the last permitted cycle when no completion arrives.
module pipe_mem_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic m_ready,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // A completion on the final cycle takes precedence over expiry
    assign expire = enable & ~m_ready & (cnt == LAST);

    // Wait-cycle counter, restarted while no access is in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !m_ready && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_mem_arb.sv
// Shares one single-port variable-latency memory between instruction fetch
// and the MEM stage. Serialises requests (data first), holds results until
// the pipeline advances, and drives the global stall.
module pipe_mem_arb
    import pipe_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          stall,
    output logic          err
);

    arb_st_t st;
    logic    if_done;
    logic    d_done;
    logic    if_pend;
    logic    d_pend;
    logic    expire;

    assign if_pend = if_req & ~if_done;
    assign d_pend  = d_req & ~d_done;
    assign stall   = if_pend | d_pend;

    pipe_mem_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (st == IDLE),
        .enable  (st != IDLE),
        .m_ready (m_ready),
        .expire  (expire)
    );

    // Sequencer: arbitration, completion capture, abort and advance handling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            // Advance cycle: pipeline moves on, both ports become eligible again
            if (!stall) begin
                if_done <= 1'b0;
                d_done  <= 1'b0;
            end
            case (st)
                IDLE: begin
                    if (stall) begin
                        // Data has fixed priority; a served port stays done
                        // until the advance, so IF cannot starve
                        if (d_pend) begin
                            st <= DACC;
                        end else begin
                            st <= IFETCH;
                        end
                    end
                end
                IFETCH: begin
                    if (m_ready) begin
                        if_rdata <= m_rdata;
                        if_done  <= 1'b1;
                        st       <= IDLE;
                    end else if (expire) begin
                        if_rdata <= DW'(NOP_WORD);
                        if_done  <= 1'b1;
                        err      <= 1'b1;
                        st       <= IDLE;
                    end
                end
                DACC: begin
                    if (m_ready) begin
                        if (!d_we) begin
                            d_rdata <= m_rdata;
                        end
                        d_done <= 1'b1;
                        st     <= IDLE;
                    end else if (expire) begin
                        d_rdata <= '0;
                        d_done  <= 1'b1;
                        err     <= 1'b1;
                        st      <= IDLE;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    // Memory port decode from registered state and the held request inputs
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (st)
            IFETCH: begin
                m_req  = 1'b1;
                m_addr = if_addr;
            end
            DACC: begin
                m_req   = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Arbiter and sequencer that shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined CPU. It serialises the two requests, holds each completed result until the pipeline advances, and drives a global `stall` that the control unit ANDs into `wpcir` and the pipeline-register enables. A watchdog aborts accesses that never complete and flags a sticky error.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, max cycles an access may wait for `m_ready` (≥2)

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  IF wants an instruction; held stable while `stall`=1
- `if_addr`  in  AW  fetch address (PC)
- `if_rdata`  out  DW  fetched instruction, held until next fetch completes
- `d_req`  in  1  MEM stage access request; held stable while `stall`=1
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, held; unchanged by stores
- `m_req`  out  1  memory request, held until `m_ready`
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid with `m_ready`
- `m_ready`  in  1  one-cycle completion pulse
- `stall`  out  1  pipeline freeze
- `err`  out  1  sticky timeout flag

## Operation
- State `st`: IDLE, IFETCH, DACC. Per-port done flags `if_done`, `d_done`.
- `stall` = (`if_req` & ~`if_done`) | (`d_req` & ~`d_done`), combinational.
- Advance cycle = any cycle with `stall`=0; at its closing edge both done flags clear.
- IDLE arbitration (evaluated only when `stall`=1): pending = req & ~done; D pending → DACC; else IF pending → IFETCH. Data has fixed priority; no starvation, since a served port stays done until advance.
- IFETCH: `m_req`=1, `m_we`=0, `m_addr`=`if_addr`. DACC: `m_req`=1, `m_we`=`d_we`, `m_addr`=`d_addr`, `m_wdata`=`d_wdata`. IDLE: `m_req`=0, `m_we`=0, other `m_*` don't-care (drive 0).
- On `m_ready` in IFETCH: `if_rdata`←`m_rdata`, `if_done`←1, st→IDLE. In DACC: if load, `d_rdata`←`m_rdata`; `d_done`←1, st→IDLE.
- `m_ready` in IDLE is ignored.
- Watchdog: counter cleared on entry to IFETCH/DACC, +1 per cycle without `m_ready`. When it reaches TIMEOUT-1 with no `m_ready`: abort. St→IDLE, `err`←1, the port's done←1, and its rdata←0 (0 = sll $0 NOP for IF).
- `m_ready` on the timeout cycle wins: normal completion, no error.
- Reset: st=IDLE, done flags 0, `if_rdata`=`d_rdata`=0, `err`=0, counter 0, so `m_req`=0 immediately. Reset mid-access drops `m_req` asynchronously; the memory must tolerate this.

## Timing
- `m_*` outputs are decoded from registered `st` plus the held request inputs, with no combinational path from `m_ready`.
- Single request, zero-wait memory: cycle 0 request seen (IDLE, stall=1); cycle 1 `m_req`=1, `m_ready`=1; cycle 2 stall=0 (advance). Stall lasts 2 cycles; each memory wait state adds 1.
- Both ports pending, zero-wait memory: D access cycles 0–1, IF access cycles 2–3, advance in cycle 4.
- `m_req` falls in the cycle after `m_ready`. There is always ≥1 IDLE cycle between accesses.
- No request is issued in the advance cycle. New requests are seen in the following cycle.

## Structure
- Package `pipe_mem_pkg`: state enum `arb_st_t` {IDLE, IFETCH, DACC}, default `AW`/`DW`, `NOP_WORD`=32'h0.
- Sub-module `pipe_mem_wdog`: parameterised TIMEOUT counter with inputs clear, enable, `m_ready` and output `expire`. Counter width is clog2(TIMEOUT).
- Top contains the FSM, done flags, data hold registers, `m_*` muxing and `stall`.

## Test plan
- Reset with `if_req`=1, `if_addr`=0x40 → `m_req`=0, `stall`=1. First edge after release: `m_req`=1, `m_addr`=0x40. `m_ready` with `m_rdata`=0x8C220004 → `if_rdata`=0x8C220004, `stall`=0 next cycle.
- Simultaneous lw (`d_addr`=0x100) and fetch (0x44), zero-wait memory → D granted first, then IF, `stall` high exactly 4 cycles. `d_rdata` and `if_rdata` get the returned words.
- sw `d_addr`=0x10, `d_wdata`=0xDEADBEEF with 3 wait states → `m_we`=1 for 4 cycles, data stable, `d_rdata` unchanged.
- Memory never asserts `m_ready` on a fetch → abort after TIMEOUT cycles: `err`=1 sticky, `if_rdata`=0, `stall` drops. `m_ready` exactly on cycle TIMEOUT-1 → no error.
- Assert `reset` in the second wait cycle of a DACC → `m_req`=0 immediately, done flags and outputs back to 0. After release, the still-held request is reissued.
- Back-to-back lw with one advance cycle between → no `m_req` during the advance cycle. The second access starts the cycle after.
